ftf_seq_encoder: RTL

Parametrised, handshaked successor to the 3-wire FTF (forbidden-transition-free) encoder. It converts a binary word into the FNS/FTF codeword for an N_TSV-wire TSV group. Conversion runs serially, one codeword bit per cycle, MSB first, so area stays flat as N_TSV grows. The TSV bus is updated atomically, all wires on one edge, so no partial codeword ever reaches the bus. The block sits between the data source and the TSV drivers, paired with the matching FNS decoder on the far die.

---
 rtl/ftf_pkg.sv | 73 +++++++
 rtl/ftf_bit_step.sv | 42 ++++
 rtl/ftf_seq_encoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/ftf_pkg.sv
// Shared definitions for the FTF/FNS serial encoder: Fibonacci weights,
// code-space size, constant representability limits and a codeword check.
package ftf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } ftf_state_e;

  // Fibonacci number with F(0)=0, F(1)=F(2)=1.
  function automatic int unsigned fib(input int unsigned n);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 0;
    b = 1;
    if (n == 0) return 0;
    for (int unsigned i = 1; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Number of legal codewords on an n-wire group.
  function automatic int unsigned ftf_num_codes(input int unsigned n);
    return fib(n + 2);
  endfunction

  // Largest value reachable by bits k-1..0 when bit k is fixed to bitk,
  // honouring the forbidden-transition rule on every adjacent pair.
  // m0/m1 track the best lower-bit sum with the current top bit at 0/1.
  function automatic int unsigned ftf_lo_max(input int unsigned k, input logic bitk);
    int unsigned m0;
    int unsigned m1;
    int unsigned n0;
    int unsigned n1;
    int unsigned w;
    m0 = 0;
    m1 = 0;
    for (int unsigned j = 0; j < k; j++) begin
      w = fib(j + 1);
      if ((j % 2) == 0) begin
        // even pair: bit j = 0 under bit j+1 = 1 is illegal
        n0 = ((w + m1) > m0) ? (w + m1) : m0;
        n1 = w + m1;
      end else begin
        // odd pair: bit j = 1 under bit j+1 = 0 is illegal
        n0 = m0;
        n1 = ((w + m1) > m0) ? (w + m1) : m0;
      end
      m0 = n0;
      m1 = n1;
    end
    return bitk ? m1 : m0;
  endfunction

  // True when the low n bits of cw contain no forbidden transition.
  function automatic logic ftf_check(input logic [31:0] cw, input int unsigned n);
    logic        ok;
    int unsigned jp;
    ok = 1'b1;
    for (int unsigned j = 0; (j + 1) < n; j++) begin
      jp = j + 1;
      if (((j % 2) == 0) && !cw[j[4:0]] && cw[jp[4:0]]) ok = 1'b0;
      if (((j % 2) == 1) && cw[j[4:0]] && !cw[jp[4:0]]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ftf_bit_step.sv
// One MSB-first conversion step: decides codeword bit k from the residual
// using constant per-bit tables built at elaboration time.
module ftf_bit_step
  import ftf_pkg::*;
#(
  parameter int unsigned N_TSV = 3,
  parameter int unsigned RW    = 3,
  parameter int unsigned KW    = 2
) (
  input  logic [RW-1:0] i_residual,
  input  logic [KW-1:0] i_k,
  output logic          o_bit,
  output logic [RW-1:0] o_residual
);

  localparam int unsigned DEPTH = 1 << KW;

  logic [RW-1:0] w_lo_tab [DEPTH];
  logic [RW-1:0] w_wt_tab [DEPTH];
  logic [RW-1:0] w_lo;
  logic [RW-1:0] w_wt;

  // Unreachable indices get a saturated limit so they never set a bit.
  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    if (g < N_TSV) begin : g_used
      assign w_lo_tab[g] = RW'(ftf_lo_max(g, 1'b0));
      assign w_wt_tab[g] = RW'(fib(g + 1));
    end else begin : g_unused
      assign w_lo_tab[g] = '1;
      assign w_wt_tab[g] = '0;
    end
  end

  // Set bit k only when the lower bits alone cannot reach the residual.
  always_comb begin
    w_lo       = w_lo_tab[i_k];
    w_wt       = w_wt_tab[i_k];
    o_bit      = (i_residual > w_lo);
    o_residual = o_bit ? (i_residual - w_wt) : i_residual;
  end

endmodule

// File: rtl/ftf_seq_encoder.sv
// Handshaked serial FTF/FNS encoder: one codeword bit per cycle, MSB first,
// with the TSV bus updated atomically from a shadow register.
module ftf_seq_encoder
  import ftf_pkg::*;
#(
  parameter  int unsigned N_TSV     = 3,
  localparam int unsigned NUM_CODES = ftf_num_codes(N_TSV),
  localparam int unsigned DIN_W     = $clog2(NUM_CODES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIN_W-1:0] in_data,
  output logic [N_TSV-1:0] tsv,
  output logic             tsv_valid,
  output logic             range_err,
  output logic             busy
);

  localparam int unsigned    KW    = (N_TSV > 1) ? $clog2(N_TSV) : 1;
  localparam logic [DIN_W:0] LIMIT = (DIN_W + 1)'(NUM_CODES);

  ftf_state_e       r_state;
  logic [DIN_W-1:0] r_residual;
  logic [KW-1:0]    r_k;
  logic [N_TSV-1:0] r_shadow;
  logic [N_TSV-1:0] r_tsv;
  logic             r_tsv_valid;
  logic             r_range_err;

  logic             w_bit;
  logic [DIN_W-1:0] w_res_next;
  logic             w_accept;
  logic             w_legal;

  ftf_bit_step #(
    .N_TSV (N_TSV),
    .RW    (DIN_W),
    .KW    (KW)
  ) u_step (
    .i_residual (r_residual),
    .i_k        (r_k),
    .o_bit      (w_bit),
    .o_residual (w_res_next)
  );

  assign in_ready  = (r_state == IDLE) && !reset;
  assign busy      = (r_state != IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_legal   = ({1'b0, in_data} < LIMIT);
  assign tsv       = r_tsv;
  assign tsv_valid = r_tsv_valid;
  assign range_err = r_range_err;

  // Control FSM: accept or reject a word, convert serially, commit atomically.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_residual  <= '0;
      r_k         <= '0;
      r_shadow    <= '0;
      r_tsv       <= '0;
      r_tsv_valid <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_tsv_valid <= 1'b0;
      r_range_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_residual <= in_data;
              r_k        <= KW'(N_TSV - 1);
              r_shadow   <= '0;
              r_state    <= CONV;
            end else begin
              r_range_err <= 1'b1;
            end
          end
        end
        CONV: begin
          r_shadow   <= r_shadow | (N_TSV'(w_bit) << r_k);
          r_residual <= w_res_next;
          r_k        <= r_k - KW'(1);
          if (r_k == '0) r_state <= COMMIT;
        end
        COMMIT: begin
          r_tsv       <= r_shadow;
          r_tsv_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A legal word is always fully consumed by the final conversion step.
  assert property (@(posedge clock) disable iff (reset)
    ((r_state == CONV) && (r_k == '0)) |-> (w_res_next == '0));

  // Every committed codeword obeys the forbidden-transition rule.
  assert property (@(posedge clock) disable iff (reset)
    (r_state == COMMIT) |-> ftf_check(32'(r_shadow), N_TSV));

endmodule
